// File: rtl/arduino_cmd_tx.sv
// Command-byte serial transmitter toward the Arduino: a small push FIFO feeding a
// start/8 data/stop framer. Define ARDUINO_CMD_TX_PARITY_EN to append even parity.
module arduino_cmd_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       tx_out,
  output logic       busy,
  output logic [4:0] fifo_count,
  output logic       drop_pulse
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [4:0]      DEPTH_C   = 5'(FIFO_DEPTH);
  localparam logic [16:0]     BIT_LAST  = 17'(CLKS_PER_BIT - 1);
  localparam logic [16:0]     STOP_LAST = 17'(STOP_BITS * CLKS_PER_BIT - 1);

`ifdef ARDUINO_CMD_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Handshake: a byte is taken on a rising edge when cmd_valid && cmd_ready;
  // cmd_valid while cmd_ready is low discards the byte and raises drop_pulse.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic [7:0]       head;

  assign cmd_ready  = (fifo_count < DEPTH_C);
  assign push       = cmd_valid && cmd_ready;
  assign drop_pulse = cmd_valid && !cmd_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  state_t      state_q, state_d;
  logic [16:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        bit_done;
`ifdef ARDUINO_CMD_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign bit_done = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef ARDUINO_CMD_TX_PARITY_EN
    par_d   = par_q;
`endif
    if ((state_q != S_IDLE) && !bit_done) timer_d = timer_q - 17'd1;

    case (state_q)
      S_IDLE: pop = (fifo_count != '0);
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          timer_d = BIT_LAST;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          idx_d   = idx_q + 3'd1;
          timer_d = BIT_LAST;
          if (idx_q == 3'd7) begin
`ifdef ARDUINO_CMD_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            timer_d = STOP_LAST;
            tx_d    = 1'b1;
`endif
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef ARDUINO_CMD_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          timer_d = STOP_LAST;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          pop     = (fifo_count != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading the next byte from IDLE or straight out of STOP: no idle gap.
    if (pop) begin
      state_d = S_START;
      timer_d = BIT_LAST;
      tx_d    = 1'b0;
      shreg_d = head;
`ifdef ARDUINO_CMD_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef ARDUINO_CMD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef ARDUINO_CMD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_out = tx_q;
  assign busy   = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Bench for arduino_cmd_tx: a 1-stop and a 2-stop instance share one command stream
// and are compared every cycle against a frame-level timing model.
module tb_arduino_cmd_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ARDUINO_CMD_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  // clock/reset and DUT wiring
  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic [7:0]      cmd_data;
  logic [1:0]      tx_w, busy_w, ready_w, drop_w;
  logic [1:0][4:0] cnt_w;

  always #5 clk = ~clk;

  arduino_cmd_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
    .CLOCK_50(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(ready_w[0]), .tx_out(tx_w[0]), .busy(busy_w[0]),
    .fifo_count(cnt_w[0]), .drop_pulse(drop_w[0]));

  arduino_cmd_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .CLOCK_50(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(ready_w[1]), .tx_out(tx_w[1]), .busy(busy_w[1]),
    .fifo_count(cnt_w[1]), .drop_pulse(drop_w[1]));

  // frame-level reference model: every accepted byte with its push and start edges
  typedef struct { int push; int start; logic [7:0] data; } acc_t;
  typedef struct { logic [7:0] data; logic par; int busy0; int busy1; } vec_t;

  acc_t       acc [2][1024];
  int         n_acc [2];
  int         prev_end [2];
  int         cyc;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] smp_drop;
  logic       lt [2][64];
  logic       lb [2][64];

  // scoreboard for instance 0: bytes in push order, consumed by a line decoder
  logic [7:0] exp_q[$];
  logic       rx_act;
  int         rx_t;
  int         rx_bit;
  logic [7:0] rx_byte;

  function automatic int flen(int k);
    return (10 + PBITS + k) * CPB;
  endfunction

  function automatic logic frame_bit(int j, logic [7:0] d);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (PBITS == 1 && j == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic int m_count(int k, int t);
    int c = 0;
    for (int i = 0; i < n_acc[k]; i++)
      if (acc[k][i].push <= t && acc[k][i].start > t) c++;
    return c;
  endfunction

  function automatic logic m_tx(int k, int t);
    for (int i = 0; i < n_acc[k]; i++)
      if (acc[k][i].start <= t && t < acc[k][i].start + flen(k))
        return frame_bit((t - acc[k][i].start) / CPB, acc[k][i].data);
    return 1'b1;
  endfunction

  function automatic logic m_busy(int k, int t);
    for (int i = 0; i < n_acc[k]; i++)
      if (acc[k][i].push <= t && t < acc[k][i].start + flen(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_push(input int k, input int t, input logic [7:0] d);
    int s;
    s = (t < prev_end[k]) ? prev_end[k] : t + 1;
    if (n_acc[k] < 1024) begin
      acc[k][n_acc[k]] = '{push: t, start: s, data: d};
      n_acc[k]++;
    end
    prev_end[k] = s + flen(k);
    if (k == 0) exp_q.push_back(d);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_acc[k]    = 0;
      prev_end[k] = -1000;
    end
    exp_q.delete();
    rx_act = 1'b0;
    rx_t   = 0;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (edge %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic rx_step(input logic s);
    if (!rx_act) begin
      if (s == 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        rx_bit = rx_t / CPB;
        if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = s;
        if (rx_bit == 8) begin
          check("rx_byte_expected", 0, 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("rx_byte_order", 0, rx_byte, exp_q.pop_front());
        end
        if (PBITS == 1 && rx_bit == 9) check("rx_parity", 0, s, ^rx_byte);
        if (rx_bit == 9 + PBITS) begin
          check("rx_stop", 0, s, 1);
          rx_act = 1'b0;
        end
      end
    end
  endtask

  // driver: one clock cycle with the given command inputs, checked before and after the edge
  task automatic cycle(input logic v, input logic [7:0] d);
    logic [1:0] rdy;
    cmd_valid = v;
    cmd_data  = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k]      = (m_count(k, cyc) < DEPTH);
      smp_drop[k] = drop_w[k];
      check("drop_pulse", k, drop_w[k], v && !rdy[k]);
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++)
      if (v && rdy[k]) m_push(k, cyc, d);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("tx_out", k, tx_w[k], m_tx(k, cyc));
      check("busy", k, busy_w[k], m_busy(k, cyc));
      check("fifo_count", k, cnt_w[k], m_count(k, cyc));
      check("cmd_ready", k, ready_w[k], m_count(k, cyc) < DEPTH);
    end
    rx_step(tx_w[0]);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cycle(1'b0, 8'h00);
      for (int k = 0; k < 2; k++) begin
        lt[k][i] = tx_w[k];
        lb[k][i] = busy_w[k];
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_w != 2'b00 || m_busy(0, cyc) || m_busy(1, cyc)) && n < 2000) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    for (int k = 0; k < 2; k++) check("idle_timeout", k, busy_w[k], 0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_tx_out", k, tx_w[k], 1);
      check("rst_fifo_count", k, cnt_w[k], 0);
      check("rst_busy", k, busy_w[k], 0);
      check("rst_cmd_ready", k, ready_w[k], 1);
      check("rst_drop_pulse", k, drop_w[k], 0);
    end
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one isolated frame, compared bit by bit against hand-derived levels
  task automatic run_vec(input vec_t v);
    logic e;
    int   nb;
    int   bl;
    wait_idle();
    cycle(1'b1, v.data);
    cycle(1'b0, 8'h00);
    capture(64);
    for (int k = 0; k < 2; k++) begin
      nb = 10 + PBITS + k;
      check("first_fall", k, lt[k][0], 0);
      for (int j = 0; j < nb; j++) begin
        if (j == 0)                     e = 1'b0;
        else if (j <= 8)                e = v.data[j-1];
        else if (PBITS == 1 && j == 9)  e = v.par;
        else                            e = 1'b1;
        check("frame_bit", k, lt[k][j*CPB + CPB/2], e);
      end
      bl = (k == 0) ? v.busy0 : v.busy1;
      check("busy_before_fall", k, lb[k][bl-1], 1);
      check("busy_fall", k, lb[k][bl], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    vec_t        post;
    logic [7:0]  burst [6];
    int          s0;
    int          rate;

    vecs[0] = '{8'hA5, 1'b0, 40 + 4*PBITS, 44 + 4*PBITS};
    vecs[1] = '{8'h07, 1'b1, 40 + 4*PBITS, 44 + 4*PBITS};
    vecs[2] = '{8'h00, 1'b0, 40 + 4*PBITS, 44 + 4*PBITS};
    vecs[3] = '{8'hFF, 1'b0, 40 + 4*PBITS, 44 + 4*PBITS};
    vecs[4] = '{8'h3C, 1'b0, 40 + 4*PBITS, 44 + 4*PBITS};
    vecs[5] = '{8'h80, 1'b1, 40 + 4*PBITS, 44 + 4*PBITS};
    post    = '{8'h01, 1'b1, 40 + 4*PBITS, 44 + 4*PBITS};
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cyc       = 0;
    model_reset();
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("init_tx_out", k, tx_w[k], 1);
      check("init_fifo_count", k, cnt_w[k], 0);
      check("init_busy", k, busy_w[k], 0);
      check("init_cmd_ready", k, ready_w[k], 1);
      check("init_drop_pulse", k, drop_w[k], 0);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // six back-to-back pushes: five fit (one in the framer, four queued)
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, burst[i]);
      for (int k = 0; k < 2; k++) begin
        check("burst_drop", k, smp_drop[k], (i == 5));
        if (i == 4) check("burst_ready_full", k, ready_w[k], 0);
      end
    end
    for (int k = 0; k < 2; k++) check("burst_count", k, cnt_w[k], 4);
    cycle(1'b0, 8'h00);
    for (int k = 0; k < 2; k++) check("drop_one_cycle", k, smp_drop[k], 0);
    wait_idle();

    // reset ten cycles into a frame, then a clean frame right after
    cycle(1'b1, 8'h3C);
    repeat (10) cycle(1'b0, 8'h00);
    for (int k = 0; k < 2; k++) check("pre_reset_tx", k, tx_w[k], 0);
    do_reset();
    run_vec(post);

    // two queued bytes: stop length between frames, push and pop on one edge
    wait_idle();
    cycle(1'b1, 8'h81);
    for (int k = 0; k < 2; k++) check("push_pop_count_a", k, cnt_w[k], 1);
    cycle(1'b1, 8'h02);
    for (int k = 0; k < 2; k++) check("push_pop_count_b", k, cnt_w[k], 1);
    capture(64);
    s0 = (9 + PBITS) * CPB;
    for (int i = 0; i < 8; i++) check("stop2_high", 1, lt[1][s0 + i], 1);
    check("stop2_next_start", 1, lt[1][s0 + 8], 0);
    check("stop1_high", 0, lt[0][s0 + 3], 1);
    check("stop1_next_start", 0, lt[0][s0 + 4], 0);
    wait_idle();

    // randomized traffic in bursts of varying density, with one reset mid-stream
    rate = 30;
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 2))
        0:       rate = 5;
        1:       rate = 35;
        default: rate = 90;
      endcase
      for (int i = 0; i < 200; i++) begin
        if (blk == 7 && i == 100) do_reset();
        cycle($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
      end
    end
    wait_idle();
    check("rx_queue_empty", 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arduino_cmd_tx.md
ARDUINO_CMD_TX -- requirements
Module: arduino_cmd_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208; CLOCK_50 cycles per serial bit (9600 baud at 50 MHz), legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4; command FIFO entries, power of two, legal range 2..16.
REQ-003 Parameter STOP_BITS, default 1; stop bits per frame, legal values 1 or 2.
REQ-004 CLOCK_50  input  1  system clock, 50 MHz, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  command byte present on cmd_data.
REQ-007 cmd_data  input  8  command byte to Arduino: [7:6] opcode, [5:3] reserved 0, [2:0] target box address.
REQ-008 cmd_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 tx_out  output  1  serial line to Arduino GPIO; idle high.
REQ-010 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 drop_pulse  output  1  one-cycle pulse when cmd_valid is high while cmd_ready is low; the byte is discarded.

Function
REQ-013 Push occurs on a rising edge with cmd_valid && cmd_ready; cmd_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-014 FSM states IDLE, START, DATA, PARITY, STOP; IDLE -> START when FIFO non-empty, popping head into an 8-bit shift register on the same edge.
REQ-015 START drives 0 for CLKS_PER_BIT cycles -> DATA.
REQ-016 DATA drives shift register LSB first, 8 bits, each CLKS_PER_BIT cycles -> PARITY (macro defined) or STOP.
REQ-017 STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles -> START directly if FIFO non-empty (popping on that edge, no idle gap), else IDLE.
REQ-018 Bit timer counts CLKS_PER_BIT-1 down to 0; bit advance on timer==0; 3-bit data index wraps 7->0 on exit from DATA.
REQ-019 Latency: byte pushed at edge N into an empty FIFO with FSM in IDLE -> popped at edge N+1 -> tx_out low from edge N+1 onward.
REQ-020 Simultaneous push and pop: both occur, fifo_count unchanged; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 Push while full: rejected, FIFO and pointers unchanged, drop_pulse high for that cycle only.
REQ-022 tx_out is a registered output; never glitches; bytes transmitted strictly in push order.
REQ-023 busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-024 On reset asserted, immediately: state IDLE, tx_out 1, FIFO emptied (count 0, pointers 0), timer 0, drop_pulse 0, busy 0, cmd_ready 1.
REQ-025 Reset mid-frame aborts the frame; tx_out returns high asynchronously; partially sent byte is not resent.
REQ-026 First push accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ARDUINO_CMD_TX_PARITY_EN defined: PARITY state inserted after DATA, drives even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits with STOP_BITS=1.
REQ-028 Macro not defined: no PARITY state or parity logic; DATA -> STOP; frame = 10 bits with STOP_BITS=1.

Verification
REQ-029 CLKS_PER_BIT=4, push 0xA5 at idle -> tx_out 0,1,0,1,0,0,1,0,1,[0 if PARITY_EN],1, each bit 4 cycles; busy falls 40 cycles (44 with PARITY_EN) after tx_out first falls.
REQ-030 CLKS_PER_BIT=4, push 6 bytes back-to-back at idle -> 5 accepted, cmd_ready low on 6th, drop_pulse one cycle; 5 frames back-to-back, no idle gap, in push order.
REQ-031 PARITY_EN, push 0x07 -> parity bit 1; push 0x00 -> parity bit 0.
REQ-032 Assert reset at cycle 10 of frame for 0x3C -> tx_out high same cycle, fifo_count 0, busy 0; next push 0x01 transmits a clean frame.
REQ-033 STOP_BITS=2, CLKS_PER_BIT=4, push 0x81 then 0x02 -> stop high 8 cycles between frames; push and pop on same edge keeps fifo_count constant.
